// File: rtl/line_buffer_multi.sv
// Multi-line delay buffer presenting one vertical tap column per accepted pixel.
// Optional top-border zero padding of unfilled rows: define LINE_BUFFER_BORDER_ZERO_EN.
module line_buffer_multi #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LINES  = 2,
    parameter int MAX_WIDTH  = 32,
    parameter int PTR_WIDTH  = $clog2(MAX_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PTR_WIDTH:0]                cfg_width,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] out_taps,
    output logic [PTR_WIDTH-1:0]              out_col,
    output logic                              out_eol,
    output logic                              out_primed
);

    localparam int FILL_WIDTH = $clog2(NUM_LINES + 1);
    localparam logic [FILL_WIDTH-1:0] FILL_FULL = FILL_WIDTH'(NUM_LINES);
    localparam logic [PTR_WIDTH:0]    WIDTH_MAX = (PTR_WIDTH + 1)'(MAX_WIDTH);
    localparam logic [PTR_WIDTH:0]    WIDTH_ONE = (PTR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [NUM_LINES][MAX_WIDTH];
    logic [DATA_WIDTH-1:0] rd  [NUM_LINES];

    logic [PTR_WIDTH-1:0]  col;
    logic [PTR_WIDTH:0]    width_q;
    logic [FILL_WIDTH-1:0] fill_cnt;

    logic                  accept;
    logic                  eol;
    logic                  primed;
    logic [PTR_WIDTH:0]    width_clamped;
    logic [(NUM_LINES+1)*DATA_WIDTH-1:0] taps_next;

    assign in_ready = !rst && !flush && (out_ready || !out_valid);
    assign accept   = in_valid && in_ready;
    assign eol      = ({1'b0, col} == (width_q - WIDTH_ONE));
    assign primed   = (fill_cnt == FILL_FULL);

    assign width_clamped = ((cfg_width == '0) || (cfg_width > WIDTH_MAX)) ? WIDTH_MAX : cfg_width;

    // Every line is read at the current column before the same edge overwrites it.
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            rd[k] = mem[k][col];
        end
    end

    always_comb begin
        taps_next = '0;
        taps_next[DATA_WIDTH-1:0] = in_data;
        for (int k = 0; k < NUM_LINES; k++) begin
`ifdef LINE_BUFFER_BORDER_ZERO_EN
            if (int'(fill_cnt) <= k) begin
                taps_next[(k+1)*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else begin
                taps_next[(k+1)*DATA_WIDTH +: DATA_WIDTH] = rd[k];
            end
`else
            taps_next[(k+1)*DATA_WIDTH +: DATA_WIDTH] = rd[k];
`endif
        end
    end

    // Line memories shift one row down per accepted pixel; they are never cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[0][col] <= in_data;
            for (int k = 1; k < NUM_LINES; k++) begin
                mem[k][col] <= rd[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_taps   <= '0;
            out_col    <= '0;
            out_eol    <= 1'b0;
            out_primed <= 1'b0;
            col        <= '0;
            fill_cnt   <= '0;
            width_q    <= WIDTH_MAX;
        end else if (flush) begin
            out_valid <= 1'b0;
            col       <= '0;
            fill_cnt  <= '0;
            width_q   <= width_clamped;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_taps   <= taps_next;
            out_col    <= col;
            out_eol    <= eol;
            out_primed <= primed;
            col        <= eol ? '0 : col + 1'b1;
            if (eol && !primed) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_multi.sv
// Directed, table-driven bench for line_buffer_multi (DATA_WIDTH=8, NUM_LINES=2, MAX_WIDTH=32).
module tb_line_buffer_multi;

    logic        clk;
    logic        rst;
    logic [5:0]  cfg_width;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_taps;
    logic [4:0]  out_col;
    logic        out_eol;
    logic        out_primed;

    int checks;
    int failures;

`ifdef LINE_BUFFER_BORDER_ZERO_EN
    localparam logic BORDER = 1'b1;
`else
    localparam logic BORDER = 1'b0;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [4:0]  col;
        logic        eol;
        logic        primed;
        logic        chk_taps;
        logic [23:0] taps;
    } vec_t;

    vec_t t1 [12];
    vec_t t3 [9];

    line_buffer_multi dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_width  (cfg_width),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_taps   (out_taps),
        .out_col    (out_col),
        .out_eol    (out_eol),
        .out_primed (out_primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] data);
        in_valid = 1'b1;
        in_data  = data;
        step();
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check_output({tag, " valid"},  {31'd0, out_valid},  32'd1);
        check_output({tag, " col"},    {27'd0, out_col},    {27'd0, v.col});
        check_output({tag, " eol"},    {31'd0, out_eol},    {31'd0, v.eol});
        check_output({tag, " primed"}, {31'd0, out_primed}, {31'd0, v.primed});
        if (v.chk_taps) begin
            check_output({tag, " taps"}, {8'd0, out_taps}, {8'd0, v.taps});
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic [4:0] c, input logic e,
                                input logic p, input logic ct, input logic [23:0] t);
        vec_t v;
        v.data = d; v.col = c; v.eol = e; v.primed = p; v.chk_taps = ct; v.taps = t;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        // Width 4 fill: taps {2 rows ago, 1 row ago, current}
        t1[0]  = mk(8'd0,  5'd0, 1'b0, 1'b0, BORDER, {8'd0, 8'd0, 8'd0});
        t1[1]  = mk(8'd1,  5'd1, 1'b0, 1'b0, BORDER, {8'd0, 8'd0, 8'd1});
        t1[2]  = mk(8'd2,  5'd2, 1'b0, 1'b0, BORDER, {8'd0, 8'd0, 8'd2});
        t1[3]  = mk(8'd3,  5'd3, 1'b1, 1'b0, BORDER, {8'd0, 8'd0, 8'd3});
        t1[4]  = mk(8'd4,  5'd0, 1'b0, 1'b0, BORDER, {8'd0, 8'd0, 8'd4});
        t1[5]  = mk(8'd5,  5'd1, 1'b0, 1'b0, BORDER, {8'd0, 8'd1, 8'd5});
        t1[6]  = mk(8'd6,  5'd2, 1'b0, 1'b0, BORDER, {8'd0, 8'd2, 8'd6});
        t1[7]  = mk(8'd7,  5'd3, 1'b1, 1'b0, BORDER, {8'd0, 8'd3, 8'd7});
        t1[8]  = mk(8'd8,  5'd0, 1'b0, 1'b1, 1'b1,   {8'd0, 8'd4, 8'd8});
        t1[9]  = mk(8'd9,  5'd1, 1'b0, 1'b1, 1'b1,   {8'd1, 8'd5, 8'd9});
        t1[10] = mk(8'd10, 5'd2, 1'b0, 1'b1, 1'b1,   {8'd2, 8'd6, 8'd10});
        t1[11] = mk(8'd11, 5'd3, 1'b1, 1'b1, 1'b1,   {8'd3, 8'd7, 8'd11});
        t1[4].taps = {8'd0, 8'd0, 8'd4};

        // Width 3 after mid-row flush: rows before primed hold stale data in the default build
        t3[0] = mk(8'd20, 5'd0, 1'b0, 1'b0, BORDER, {8'd0, 8'd0, 8'd20});
        t3[1] = mk(8'd21, 5'd1, 1'b0, 1'b0, BORDER, {8'd0, 8'd0, 8'd21});
        t3[2] = mk(8'd22, 5'd2, 1'b1, 1'b0, BORDER, {8'd0, 8'd0, 8'd22});
        t3[3] = mk(8'd23, 5'd0, 1'b0, 1'b0, BORDER, {8'd0, 8'd20, 8'd23});
        t3[4] = mk(8'd24, 5'd1, 1'b0, 1'b0, BORDER, {8'd0, 8'd21, 8'd24});
        t3[5] = mk(8'd25, 5'd2, 1'b1, 1'b0, BORDER, {8'd0, 8'd22, 8'd25});
        t3[6] = mk(8'd26, 5'd0, 1'b0, 1'b1, 1'b1,   {8'd20, 8'd23, 8'd26});
        t3[7] = mk(8'd27, 5'd1, 1'b0, 1'b1, 1'b1,   {8'd21, 8'd24, 8'd27});
        t3[8] = mk(8'd28, 5'd2, 1'b1, 1'b1, 1'b1,   {8'd22, 8'd25, 8'd28});

        rst       = 1'b1;
        cfg_width = 6'd4;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        #12;

        check_output("reset out_valid",  {31'd0, out_valid},  32'd0);
        check_output("reset out_taps",   {8'd0, out_taps},    32'd0);
        check_output("reset out_col",    {27'd0, out_col},    32'd0);
        check_output("reset out_eol",    {31'd0, out_eol},    32'd0);
        check_output("reset out_primed", {31'd0, out_primed}, 32'd0);
        check_output("reset in_ready",   {31'd0, in_ready},   32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("idle in_ready", {31'd0, in_ready}, 32'd1);

        // T1
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(t1[i].data);
            check_vec($sformatf("T1 px%0d", t1[i].data), t1[i]);
        end

        // T2 backpressure
        apply_stimulus(8'd12);
        check_vec("T2 px12", mk(8'd12, 5'd0, 1'b0, 1'b1, 1'b1, {8'd4, 8'd8, 8'd12}));
        out_ready = 1'b0;
        in_data   = 8'd13;
        #1;
        check_output("T2 in_ready held", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        check_vec("T2 stall", mk(8'd12, 5'd0, 1'b0, 1'b1, 1'b1, {8'd4, 8'd8, 8'd12}));
        out_ready = 1'b1;
        #1;
        check_output("T2 in_ready release", {31'd0, in_ready}, 32'd1);
        apply_stimulus(8'd13);
        check_vec("T2 px13", mk(8'd13, 5'd1, 1'b0, 1'b1, 1'b1, {8'd5, 8'd9, 8'd13}));
        apply_stimulus(8'd14);
        check_vec("T2 px14", mk(8'd14, 5'd2, 1'b0, 1'b1, 1'b1, {8'd6, 8'd10, 8'd14}));
        apply_stimulus(8'd15);
        check_vec("T2 px15", mk(8'd15, 5'd3, 1'b1, 1'b1, 1'b1, {8'd7, 8'd11, 8'd15}));
        in_valid = 1'b0;
        step();
        check_output("T2 drain out_valid", {31'd0, out_valid}, 32'd0);

        // T3 flush mid-row
        apply_stimulus(8'd16);
        check_output("T3 px16 col", {27'd0, out_col}, 32'd0);
        apply_stimulus(8'd17);
        check_output("T3 px17 col", {27'd0, out_col}, 32'd1);
        flush     = 1'b1;
        cfg_width = 6'd3;
        in_data   = 8'd99;
        #1;
        check_output("T3 in_ready flush", {31'd0, in_ready}, 32'd0);
        step();
        check_output("T3 flush out_valid", {31'd0, out_valid}, 32'd0);
        flush     = 1'b0;
        cfg_width = 6'd7;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(t3[i].data);
            check_vec($sformatf("T3 px%0d", t3[i].data), t3[i]);
        end

        // T4 clamp of zero width to MAX_WIDTH
        in_valid  = 1'b0;
        flush     = 1'b1;
        cfg_width = 6'd0;
        step();
        flush = 1'b0;
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(8'(40 + i));
            check_output($sformatf("T4 col %0d", i), {27'd0, out_col}, i);
            check_output($sformatf("T4 eol %0d", i), {31'd0, out_eol}, (i == 31) ? 32'd1 : 32'd0);
            check_output($sformatf("T4 primed %0d", i), {31'd0, out_primed}, 32'd0);
        end

        // T5 asynchronous reset mid-row
        apply_stimulus(8'd80);
        apply_stimulus(8'd81);
        check_output("T5 pre col", {27'd0, out_col}, 32'd1);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_output("T5 out_valid", {31'd0, out_valid},  32'd0);
        check_output("T5 out_taps",  {8'd0, out_taps},    32'd0);
        check_output("T5 out_col",   {27'd0, out_col},    32'd0);
        check_output("T5 out_eol",   {31'd0, out_eol},    32'd0);
        check_output("T5 primed",    {31'd0, out_primed}, 32'd0);
        check_output("T5 in_ready",  {31'd0, in_ready},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(8'd90);
        check_output("T5 first valid",  {31'd0, out_valid},  32'd1);
        check_output("T5 first col",    {27'd0, out_col},    32'd0);
        check_output("T5 first primed", {31'd0, out_primed}, 32'd0);
        check_output("T5 first slice0", {24'd0, out_taps[7:0]}, 32'd90);
        if (BORDER) begin
            check_output("T5 first border", {8'd0, out_taps}, {8'd0, 8'd0, 8'd0, 8'd90});
        end
        in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
